// File: rtl/spi_adc_pkg.sv
// Shared encodings for the SPI ADC responder: default widths, command bit positions, FSM states.
// The TRAIL state exists only when SPI_LSBF_EN is defined.
package spi_adc_pkg;

  localparam int DATA_W_DEF      = 12;
  localparam int CMD_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int CMD_START = 3;
  localparam int CMD_SGL   = 2;
  localparam int CMD_ODD   = 1;
  localparam int CMD_MSBF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_NULL  = 3'd2,
    ST_DATA  = 3'd3,
`ifdef SPI_LSBF_EN
    ST_TRAIL = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin with rise/fall strobes.
// Strobes are one clk wide and derived from the last synced stage and its delayed copy.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= {SYNC_STAGES{RST_VAL}};
      level_d <= RST_VAL;
    end else begin
      sync    <= (sync << 1) | SYNC_STAGES'(d);
      level_d <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a 12-bit two-channel ADC, oversampled on clk_i.
// Optional SPI_LSBF_EN: msbf=0 appends bits 1..DATA_W-1 LSB first after the MSB-first word.
//
// state | meaning
// IDLE  | waiting for cs fall, miso high
// CMD   | shifting in start/sgl/odd/msbf on dclk rises
// NULL  | next fall drives the null bit (0)
// DATA  | each fall drives the next sample bit, MSB first
// TRAIL | each fall drives bits 1..DATA_W-1 LSB first (SPI_LSBF_EN only)
// DONE  | frame complete, miso high after next fall, waiting for cs rise
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CMD_W       = CMD_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] sample_ch0_i,
  input  logic [DATA_W-1:0] sample_ch1_i,
  output logic [2:0]        cmd_o,
  output logic              frame_done_o,
  output logic              frame_err_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);

  logic dclk_rise, dclk_fall, cs_rise, cs_fall, mosi_s;
  logic unused_dclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall, unused_start;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dclk (
    .clk(clk_i), .rst(rst_i), .d(dclk_i),
    .level(unused_dclk_lvl), .rise(dclk_rise), .fall(dclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk_i), .rst(rst_i), .d(cs_i),
    .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk_i), .rst(rst_i), .d(mosi_i),
    .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t             state;
  logic [CMD_W-1:0]   cmd_sr;
  logic [CMD_W-1:0]   cmd_next;
  logic [CNT_W-1:0]   bitcnt;
  logic [DATA_W-1:0]  shreg;

  assign cmd_next     = {cmd_sr[CMD_W-2:0], mosi_s};
  assign unused_start = cmd_sr[CMD_W-1];

  always_ff @(posedge clk_i) begin
    frame_done_o <= 1'b0;
    frame_err_o  <= 1'b0;
    if (rst_i) begin
      state  <= ST_IDLE;
      cmd_sr <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      miso_o <= 1'b1;
      cmd_o  <= '0;
    end else if (cs_rise && state != ST_IDLE) begin
      // cs rise outranks any dclk edge arriving on the same clk
      if (state == ST_DONE) frame_done_o <= 1'b1;
      else                  frame_err_o  <= 1'b1;
      state  <= ST_IDLE;
      miso_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          miso_o <= 1'b1;
          if (cs_fall) begin
            state  <= ST_CMD;
            bitcnt <= '0;
            cmd_sr <= '0;
          end
        end
        ST_CMD: if (dclk_rise) begin
          cmd_sr <= cmd_next;
          if (bitcnt == '0 && !mosi_s) begin
            frame_err_o <= 1'b1;
            state       <= ST_IDLE;
          end else if (bitcnt == CMD_LAST) begin
            cmd_o  <= {cmd_next[CMD_SGL], cmd_next[CMD_ODD], cmd_next[CMD_MSBF]};
            shreg  <= cmd_next[CMD_ODD] ? sample_ch1_i : sample_ch0_i;
            state  <= ST_NULL;
            bitcnt <= '0;
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        ST_NULL: if (dclk_fall) begin
          miso_o <= 1'b0;
          state  <= ST_DATA;
        end
        ST_DATA: if (dclk_fall) begin
          // rotate so the snapshot is intact again for the trailing LSB-first pass
          miso_o <= shreg[DATA_W-1];
          shreg  <= {shreg[DATA_W-2:0], shreg[DATA_W-1]};
          if (bitcnt == DATA_LAST) state  <= ST_DONE;
          else                     bitcnt <= bitcnt + 1'b1;
`ifdef SPI_LSBF_EN
          if (bitcnt == DATA_LAST && !cmd_o[CMD_MSBF]) begin
            state  <= ST_TRAIL;
            bitcnt <= CNT_W'(1);
          end
`endif
        end
`ifdef SPI_LSBF_EN
        ST_TRAIL: if (dclk_fall) begin
          miso_o <= shreg[1];
          shreg  <= {shreg[0], shreg[DATA_W-1:1]};
          if (bitcnt == DATA_LAST) state  <= ST_DONE;
          else                     bitcnt <= bitcnt + 1'b1;
        end
`endif
        ST_DONE: if (dclk_fall) miso_o <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomized scoreboard bench for spi_adc_responder; a bit-bang SPI master drives frames,
// a reference model predicts each frame's outcome and a forked monitor checks every pulse.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst_i, dclk, cs, mosi, miso;
  logic [11:0] ch0, ch1;
  logic [2:0]  cmd_o;
  logic        done, err;

  always #5 clk = ~clk;

  spi_adc_responder dut (
    .clk_i(clk), .rst_i(rst_i), .dclk_i(dclk), .cs_i(cs), .mosi_i(mosi), .miso_o(miso),
    .sample_ch0_i(ch0), .sample_ch1_i(ch1), .cmd_o(cmd_o),
    .frame_done_o(done), .frame_err_o(err)
  );

`ifdef SPI_LSBF_EN
  localparam bit LSBF = 1'b1;
`else
  localparam bit LSBF = 1'b0;
`endif

  typedef struct {
    bit          is_done;
    logic [2:0]  cmd;
    logic [63:0] bits;
    int          n;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  model_cmd = 3'b000;
  logic [63:0] cap_bits;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_n(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic int frame_len(input logic [3:0] c);
    return 17 + ((LSBF && !c[0]) ? 11 : 0);
  endfunction

  // Bits the master should see on successive dclk rises, padded with idle-high ones.
  function automatic logic [63:0] model_stream(input logic [3:0] c, input logic [11:0] c0,
                                               input logic [11:0] c1);
    bit q[$];
    logic [11:0] s;
    logic [63:0] r;
    s = c[1] ? c1 : c0;
    if (c[3]) begin
      q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 11; i >= 0; i--) q.push_back(s[i]);
      if (LSBF && !c[0]) for (int i = 1; i <= 11; i++) q.push_back(s[i]);
    end
    r = '1;
    for (int k = 0; k < q.size(); k++) r[k] = q[k];
    return r;
  endfunction

  task automatic chk_reset(input string name);
    chk(miso === 1'b1 && cmd_o === 3'b000 && done === 1'b0 && err === 1'b0, name,
        {58'd0, miso, cmd_o, done, err}, 64'h20);
  endtask

  task automatic run_frame(input logic [3:0] c, input logic [11:0] c0, input logic [11:0] c1,
                           input int ncyc, input bit do_rst);
    exp_t e;
    e.bits    = model_stream(c, c0, c1);
    e.is_done = c[3] && (ncyc >= frame_len(c) - 1);
    if (c[3] && ncyc >= 4) model_cmd = c[2:0];
    e.cmd = model_cmd;
    e.n   = c[3] ? ncyc : 1;
    if (do_rst) model_cmd = 3'b000;
    else        sbq.push_back(e);

    ch0 = c0; ch1 = c1; cap_bits = '1;
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      mosi = (k < 4) ? c[3-k] : 1'($urandom);
      repeat (8) @(negedge clk);
      dclk = 1'b1;
      cap_bits[k] = miso;
      if (k == 4) begin
        ch0 = 12'($urandom);
        ch1 = 12'($urandom);
      end
      repeat (8) @(negedge clk);
      dclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    if (do_rst) begin
      rst_i = 1'b1; cs = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk_reset("midframe_reset");
      repeat (20) @(negedge clk);
    end else begin
      cs = 1'b1;
      repeat (16) @(negedge clk);
    end
    if (!c[3])
      chk((cap_bits & mask_n(ncyc)) == mask_n(ncyc), "miso_idle_high",
          cap_bits & mask_n(ncyc), mask_n(ncyc));
  endtask

  task automatic monitor();
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && (done || err)) begin
        chk(!prev, "pulse_width", {63'd0, prev}, 64'd0);
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_pulse", {62'd0, done, err}, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk(done == e.is_done && err == !e.is_done, "pulse_kind",
              {62'd0, done, err}, {62'd0, e.is_done, !e.is_done});
          chk(cmd_o === e.cmd, "cmd_o", {61'd0, cmd_o}, {61'd0, e.cmd});
          chk((cap_bits & mask_n(e.n)) === (e.bits & mask_n(e.n)), "miso_bits",
              cap_bits & mask_n(e.n), e.bits & mask_n(e.n));
        end
      end
      prev = !rst_i && (done || err);
    end
  endtask

  initial begin
    logic [3:0] c;
    int         n;
    rst_i = 1'b1; dclk = 1'b0; cs = 1'b1; mosi = 1'b0; ch0 = '0; ch1 = '0; cap_bits = '1;
    fork
      monitor();
    join_none
    repeat (4) @(negedge clk);
    chk_reset("reset_values");
    rst_i = 1'b0;
    repeat (4) @(negedge clk);

    run_frame(4'b1101, 12'h000, 12'hA5C, frame_len(4'b1101), 1'b0);
    run_frame(4'b1001, 12'hFFF, 12'h123, frame_len(4'b1001), 1'b0);
    run_frame(4'b0101, 12'h3C3, 12'h5A5, 17, 1'b0);
    run_frame(4'b1001, 12'h456, 12'h789, 10, 1'b0);
    run_frame(4'b1001, 12'h800, 12'h000, frame_len(4'b1001), 1'b0);
    run_frame(4'b1101, 12'h111, 12'h9E7, 9, 1'b1);
    run_frame(4'b1101, 12'h222, 12'hB3D, frame_len(4'b1101), 1'b0);
    run_frame(4'b1100, 12'h0F1, 12'hFFF, frame_len(4'b1100), 1'b0);
    run_frame(4'b1110, 12'hC35, 12'h6A9, 3, 1'b0);

    for (int r = 0; r < 24; r++) begin
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) c[3] = 1'b1;
      n = ($urandom_range(0, 2) != 0) ? frame_len(c) : $urandom_range(0, 14);
      run_frame(c, 12'($urandom), 12'($urandom), n, 1'b0);
    end

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk(sbq.size() == 0, "pending_frames", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
Synthesizable SPI responder that models the 12-bit, two-channel ADC at the far end of the spi_one_ch link. It runs on the system clock and oversamples dclk, cs and mosi. It decodes the command the master shifts in and returns a 12-bit sample on miso. It is used as the on-chip loopback target for spi_one_ch and as a bench model in place of the external ADC.

Parameters:
DATA_W, 12, sample width in bits returned per frame
CMD_W, 4, command bits shifted in: start, sgl/diff, odd (channel), msbf
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (dclk, cs, mosi)

Ports:
clk_i  in  1  system clock; all logic on the rising edge
rst_i  in  1  synchronous reset, active-high
dclk_i  in  1  SPI serial clock from master; idle low, mode 0
cs_i  in  1  chip select from master, active-low
mosi_i  in  1  serial command from master
miso_o  out  1  serial data to master
sample_ch0_i  in  DATA_W  value returned when odd=0
sample_ch1_i  in  DATA_W  value returned when odd=1
cmd_o  out  3  last decoded {sgl, odd, msbf}; held until next valid command
frame_done_o  out  1  one-clk pulse when a complete frame ends with cs rising
frame_err_o  out  1  one-clk pulse on an aborted or invalid frame

Behaviour:
- Reset values: miso_o=1, cmd_o=0, frame_done_o=0, frame_err_o=0, FSM=IDLE, all sync flops cleared to their idle levels (dclk 0, cs 1, mosi 0).
- Each input passes through SYNC_STAGES flops. Edge detect compares the last synced value with a one-clk-delayed copy.
- Internal edge strobes lag the pins by SYNC_STAGES+1 clk. clk_i must be at least 8x dclk.
- rise = synced dclk 0->1; fall = synced dclk 1->0; cs_fall / cs_rise are defined the same way.
- FSM states: IDLE, CMD, NULL, DATA, TRAIL (TRAIL is present only with the optional feature), DONE.
- IDLE: miso_o=1. On cs_fall, go to CMD and clear the bit counter.
- CMD: on each rise, shift mosi into a CMD_W register, MSB first.
  - If the first sampled bit (start) is 0, go to IDLE and pulse frame_err_o.
  - After the CMD_W-th rise, update cmd_o and latch the selected sample_chX_i into the shift register (single snapshot; later input changes are ignored). Go to NULL.
- NULL: on the next fall, drive miso_o=0 (null bit), then go to DATA.
- DATA: on each fall, drive the next sample bit, MSB first. The bit counter runs 0..DATA_W-1.
  - After the fall that drives bit 0, go to DONE; miso_o holds bit 0.
- DONE: miso_o=1 from the next fall onward. Further dclk edges are ignored.
- Frame end: cs_rise in DONE pulses frame_done_o for 1 clk and returns to IDLE with miso_o=1 on the same clk.
- cs_rise in CMD, NULL, DATA or TRAIL pulses frame_err_o, returns to IDLE and sets miso_o=1. cmd_o keeps its last value unless CMD had already completed.
- Simultaneous cs_rise and an dclk edge in the same clk: cs_rise wins and the dclk edge is discarded.
- cs_fall while not in IDLE cannot occur (cs is already low) and needs no handling.
- rst_i mid-frame: immediate return to reset values on the next clk. The in-flight frame is lost and no pulse is issued.
- The bit counter is ceil(log2(DATA_W)) bits wide and saturates at DONE; it never wraps.

Optional Feature:
SPI_LSBF_EN
- Defined: if the latched msbf bit = 0, the fall after bit 0 enters TRAIL instead of DONE. TRAIL drives bits 1..DATA_W-1 LSB first (DATA_W-1 extra bits), then goes to DONE.
- Not defined: the msbf bit is decoded into cmd_o only. The frame always ends after DATA_W data bits, and the TRAIL state is not built.

Decomposition:
- Shared package/include spi_adc_pkg: state encodings, CMD bit positions (START=3, SGL=2, ODD=1, MSBF=0), and the default widths.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detector. It is instantiated three times (dclk, cs, mosi; the mosi instance uses only the level output).

Test Plan:
- Master sends cmd 4'b1101, ch1=12'hA5C, ch0=12'h000 → miso after the command reads 0 then 1010_0101_1100; cmd_o=3'b101; frame_done_o pulses once on cs rise.
- Cmd 4'b1001 with ch0=12'hFFF and ch1=12'h123 → channel 0 returned, 0_1111_1111_1111; cmd_o=3'b001.
- Start bit 0 (cmd 4'b0101) → frame_err_o pulses after the first dclk rise; miso_o stays 1 for the whole frame; cmd_o unchanged.
- cs raised after 5 of 12 data bits → frame_err_o=1 for 1 clk, miso_o=1, FSM=IDLE. A following full frame with ch0=12'h800 returns correct data.
- rst_i asserted for 1 clk mid-DATA → all outputs at reset values the next clk, no done/err pulse. The next frame decodes normally.
- With SPI_LSBF_EN defined, cmd 4'b1100 and ch0=12'h0F1 → 0, 0000_1111_0001, then 000_1111_0000 (bits 1..11 LSB first), then frame_done_o. Without the macro, the same frame stops after 12 data bits.
